fletcher_checker: RTL and testbench
===================================

FLETCHER_CHECKER -- requirements
Module: fletcher_checker

Interface
REQ-001 Parameter: CHECKSUM_WIDTH, default 16, total checksum width; byte/lane width DW = CHECKSUM_WIDTH/2; modulus M = 2^DW - 1.
REQ-002 Parameter: COUNT_WIDTH, default 16, width of the saturating accepted-word counter.
REQ-003 clock_i  input  1  single clock; all state on rising edge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 valid_i  input  1  data_i carries a stream word this cycle.
REQ-006 data_i  input  DW  stream word: payload followed by the two check words (c0 first, then c1).
REQ-007 last_i  input  1  qualifies the final word of a frame when valid_i=1.
REQ-008 clear_i  input  1  synchronous abort; discards the frame in progress.
REQ-009 ready_o  output  1  word accepted on an edge where valid_i=1 and ready_o=1.
REQ-010 done_o  output  1  one-cycle pulse marking frame verdict.
REQ-011 pass_o  output  1  frame verdict: both residues zero and length legal.
REQ-012 length_error_o  output  1  frame held fewer than 3 words.
REQ-013 count_o  output  COUNT_WIDTH  accepted words in the last completed frame.

Function
REQ-014 The FSM SHALL have states IDLE, ACCUM and RESULT.
REQ-015 IDLE: ready_o=1; an accepted word loads sums, sets count=1, and goes to ACCUM; if last_i is also set, it goes straight to RESULT.
REQ-016 ACCUM: ready_o=1; each accepted word updates sums and count; an accepted word with last_i=1 goes to RESULT.
REQ-017 RESULT: ready_o=0 for exactly one cycle, done_o=1, then return to IDLE with sum1, sum2 and count cleared.
REQ-018 Per accepted word: sum1' = (sum1 + data_i) mod M, then sum2' = (sum2 + sum1') mod M.
REQ-019 Both sums SHALL stay in 0..M-1, using one conditional subtract of M (the all-ones value reduces to 0).
REQ-020 Verdict in RESULT: pass_o = (sum1==0 && sum2==0 && count>=3); length_error_o = (count<3).
REQ-021 pass_o, length_error_o and count_o SHALL be registered on entry to RESULT.
REQ-022 pass_o, length_error_o and count_o SHALL hold until the next RESULT entry.
REQ-023 Latency: done_o SHALL assert in the cycle immediately after the edge that accepts the last_i word.
REQ-024 valid_i gaps (valid_i=0) in IDLE or ACCUM SHALL leave all state unchanged.
REQ-025 A word presented during RESULT SHALL NOT be accepted; the source holds it.
REQ-026 The word counter SHALL saturate at 2^COUNT_WIDTH-1 with no wrap, and sums keep accumulating.
REQ-027 clear_i=1 SHALL force IDLE and zero the sums and counter, with no done_o pulse.
REQ-028 clear_i SHALL take priority over a simultaneous valid_i/last_i.
REQ-029 clear_i SHALL leave the held verdict outputs unchanged.

Reset
REQ-030 reset_i=1 SHALL asynchronously force IDLE, with sums=0 and counter=0.
REQ-031 Reset values: ready_o=0 while reset_i=1, then 1 in IDLE; done_o=0; pass_o=0; length_error_o=0; count_o=0.
REQ-032 Reset mid-frame SHALL discard the partial frame; the first frame after release SHALL be verified independently.

Structure
REQ-033 Shared package fletcher_pkg SHALL hold the state enum, the default CHECKSUM_WIDTH and a modulus constant/function derived from the width.
REQ-034 Sub-module fletcher_mod_add SHALL be a combinational (a + b) mod M adder with a conditional subtract, instantiated twice (sum1, sum2).

Verification
REQ-035 01,02,F8,04 (last on 04) -> done_o one cycle later; pass_o=1, length_error_o=0, count_o=4.
REQ-036 61,62,63,64,65,46,C8 -> pass_o=1, count_o=7.
REQ-037 61..66,88,20 -> pass_o=1; same frame with the final word 21 -> pass_o=0.
REQ-038 FF,FF,FF -> pass_o=1 (checks all-ones reduction to 0).
REQ-039 Single word 01 with last -> pass_o=0, length_error_o=1, count_o=1.
REQ-040 Random valid_i gaps, back-to-back frames, clear_i mid-frame, and reset_i mid-frame -> verdicts match a reference model, with no done_o for aborted frames.

Source files
------------

// File: rtl/fletcher_pkg.sv
// Shared definitions for the Fletcher checksum checker: FSM states,
// default checksum width and the lane modulus.
package fletcher_pkg;

    localparam int DEFAULT_CHECKSUM_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

    // Lane modulus 2^dw - 1 for a lane of dw bits
    function automatic int unsigned modulus(input int unsigned dw);
        return (32'd1 << dw) - 32'd1;
    endfunction

endpackage

// File: rtl/fletcher_mod_add.sv
// Combinational (a + b) mod (2^DW - 1) adder. One conditional subtract is
// enough because a is always reduced and b is at most the all-ones value;
// an all-ones result folds to zero.
module fletcher_mod_add
    import fletcher_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum
);

    localparam logic [DW:0] MOD = (DW+1)'(modulus(DW));

    logic [DW:0] raw;
    logic [DW:0] reduced;

    // Widened add followed by a single reduction step
    always_comb begin
        raw     = {1'b0, a} + {1'b0, b};
        reduced = (raw >= MOD) ? (raw - MOD) : raw;
        sum     = reduced[DW-1:0];
    end

endmodule

// File: rtl/fletcher_checker.sv
// Streaming Fletcher checksum verifier. Accumulates sum1/sum2 over a frame
// (payload plus the two check words) and reports a one-cycle verdict pulse
// with held pass/length/count results.
module fletcher_checker
    import fletcher_pkg::*;
#(
    parameter int CHECKSUM_WIDTH = DEFAULT_CHECKSUM_WIDTH,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      valid_i,
    input  logic [CHECKSUM_WIDTH/2-1:0] data_i,
    input  logic                      last_i,
    input  logic                      clear_i,
    output logic                      ready_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic                      length_error_o,
    output logic [COUNT_WIDTH-1:0]    count_o
);

    localparam int DW = CHECKSUM_WIDTH / 2;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] MIN_LEN   = COUNT_WIDTH'(3);

    state_t state;
    state_t state_next;

    logic [DW-1:0]          sum1;
    logic [DW-1:0]          sum2;
    logic [DW-1:0]          sum1_next;
    logic [DW-1:0]          sum2_next;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   accept;

    // sum2 consumes the freshly updated sum1, so the adders are chained
    fletcher_mod_add #(.DW(DW)) u_sum1 (
        .a   (sum1),
        .b   (data_i),
        .sum (sum1_next)
    );

    fletcher_mod_add #(.DW(DW)) u_sum2 (
        .a   (sum2),
        .b   (sum1_next),
        .sum (sum2_next)
    );

    // Word counter saturates instead of wrapping; clear always wins over a word
    always_comb begin
        count_next = (count == COUNT_MAX) ? count : count + COUNT_WIDTH'(1);
        accept     = valid_i && ready_o && !clear_i;
    end

    // State register
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, handshake and verdict pulse
    always_comb begin
        state_next = state;
        ready_o    = 1'b0;
        done_o     = 1'b0;
        case (state)
            IDLE: begin
                ready_o = !reset_i;
                if (clear_i) begin
                    state_next = IDLE;
                end else if (valid_i) begin
                    state_next = last_i ? RESULT : ACCUM;
                end
            end
            ACCUM: begin
                ready_o = !reset_i;
                if (clear_i) begin
                    state_next = IDLE;
                end else if (valid_i && last_i) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Running sums and word count; zeroed on abort and after each verdict
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sum1  <= '0;
            sum2  <= '0;
            count <= '0;
        end else if (clear_i || state == RESULT) begin
            sum1  <= '0;
            sum2  <= '0;
            count <= '0;
        end else if (accept) begin
            sum1  <= sum1_next;
            sum2  <= sum2_next;
            count <= count_next;
        end
    end

    // Verdict captured on the edge that accepts the final word, held until the next one
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            pass_o         <= 1'b0;
            length_error_o <= 1'b0;
            count_o        <= '0;
        end else if (accept && last_i) begin
            pass_o         <= (sum1_next == '0) && (sum2_next == '0) && (count_next >= MIN_LEN);
            length_error_o <= (count_next < MIN_LEN);
            count_o        <= count_next;
        end
    end

endmodule

// File: tb/tb_fletcher_checker.sv
// Randomized bench for fletcher_checker with a frame-level reference model
// and a handful of hand-computed frames.
module tb_fletcher_checker;

    localparam int CW   = 16;
    localparam int DW   = 8;
    localparam int CNTW = 4;
    localparam int M    = 255;
    localparam int CMAX = 15;

    logic            clock_i = 1'b0;
    logic            reset_i = 1'b1;
    logic            valid_i = 1'b0;
    logic [DW-1:0]   data_i  = '0;
    logic            last_i  = 1'b0;
    logic            clear_i = 1'b0;
    logic            ready_o;
    logic            done_o;
    logic            pass_o;
    logic            length_error_o;
    logic [CNTW-1:0] count_o;

    int checks = 0;
    int errors = 0;

    always #5 clock_i = ~clock_i;

    fletcher_checker #(
        .CHECKSUM_WIDTH (CW),
        .COUNT_WIDTH    (CNTW)
    ) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .valid_i        (valid_i),
        .data_i         (data_i),
        .last_i         (last_i),
        .clear_i        (clear_i),
        .ready_o        (ready_o),
        .done_o         (done_o),
        .pass_o         (pass_o),
        .length_error_o (length_error_o),
        .count_o        (count_o)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: frame contents in a queue, verdict computed from the
    // Fletcher definition when the final word is taken.
    bit          m_busy = 1'b0;
    int          m_words[$];
    bit          m_pass = 1'b0;
    bit          m_len  = 1'b0;
    int          m_cnt  = 0;

    always @(posedge clock_i or posedge reset_i) begin : model
        int s1, s2, c;
        if (reset_i) begin
            m_busy = 1'b0;
            m_words.delete();
            m_pass = 1'b0;
            m_len  = 1'b0;
            m_cnt  = 0;
        end else if (m_busy) begin
            m_busy = 1'b0;
        end else if (clear_i) begin
            m_words.delete();
        end else if (valid_i) begin
            m_words.push_back(int'(data_i));
            if (last_i) begin
                s1 = 0;
                s2 = 0;
                foreach (m_words[i]) begin
                    s1 = (s1 + m_words[i]) % M;
                    s2 = (s2 + s1) % M;
                end
                c = (m_words.size() > CMAX) ? CMAX : m_words.size();
                m_pass = (s1 == 0) && (s2 == 0) && (c >= 3);
                m_len  = (c < 3);
                m_cnt  = c;
                m_busy = 1'b1;
                m_words.delete();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock_i) begin
        check("ready", int'(ready_o), int'(!m_busy && !reset_i));
        check("done", int'(done_o), int'(m_busy));
        check("pass", int'(pass_o), int'(m_pass));
        check("length_error", int'(length_error_o), int'(m_len));
        check("count", int'(count_o), m_cnt);
    end

    logic [DW-1:0] fq[$];

    task automatic cycle();
        @(posedge clock_i);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Present one word and hold it until accepted (bounded)
    task automatic put(input logic [DW-1:0] d, input logic l);
        int  n;
        bit  acc;
        n = 0;
        acc = 1'b0;
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        while (!acc) begin
            @(negedge clock_i);
            acc = ready_o && !clear_i && !reset_i;
            cycle();
            n++;
            if (!acc && n > 8) begin
                checks++;
                errors++;
                $display("FAIL put_timeout at %0t: got ready=%0d, want 1", $time, ready_o);
                acc = 1'b1;
            end
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic send_fq(input int max_gap);
        for (int i = 0; i < fq.size(); i++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            put(fq[i], i == fq.size() - 1);
        end
    endtask

    // Hand-computed verdict, sampled right after the final-word edge
    task automatic expect_lit(input string name, input int p, input int le, input int c);
        check({name, "_done"}, int'(done_o), 1);
        check({name, "_pass"}, int'(pass_o), p);
        check({name, "_len"}, int'(length_error_o), le);
        check({name, "_count"}, int'(count_o), c);
    endtask

    // Append the two check words that make the queued payload verify
    function automatic void seal();
        int s1, s2, s1a, c0, c1;
        s1 = 0;
        s2 = 0;
        foreach (fq[i]) begin
            s1 = (s1 + int'(fq[i])) % M;
            s2 = (s2 + s1) % M;
        end
        s1a = (M - s2) % M;
        c0  = (s1a - s1 + M) % M;
        c1  = (M - s1a) % M;
        fq.push_back(DW'(c0));
        fq.push_back(DW'(c1));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog at %0t: got no finish, want finish", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int len, mode, abort_at;
        reset_i = 1'b1;
        idle(3);
        reset_i = 1'b0;
        #1;
        check("rst_ready", int'(ready_o), 1);
        check("rst_done", int'(done_o), 0);
        check("rst_pass", int'(pass_o), 0);
        check("rst_len", int'(length_error_o), 0);
        check("rst_count", int'(count_o), 0);
        idle(1);

        fq = '{8'h01, 8'h02, 8'hF8, 8'h04};
        send_fq(0);
        expect_lit("f4", 1, 0, 4);
        idle(1);

        fq = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h46, 8'hC8};
        send_fq(2);
        expect_lit("f7", 1, 0, 7);

        fq = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h88, 8'h20};
        send_fq(0);
        expect_lit("f8", 1, 0, 8);

        fq = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h88, 8'h21};
        send_fq(1);
        expect_lit("f8bad", 0, 0, 8);

        fq = '{8'hFF, 8'hFF, 8'hFF};
        send_fq(0);
        expect_lit("ones", 1, 0, 3);

        fq = '{8'h01};
        send_fq(0);
        expect_lit("single", 0, 1, 1);

        // Counter saturation: 20 words still verify with the count pinned
        fq.delete();
        for (int i = 0; i < 18; i++) fq.push_back(DW'($urandom_range(0, 255)));
        seal();
        send_fq(0);
        expect_lit("sat", 1, 0, CMAX);

        // Clear mid-frame, then a clean frame must verify on its own
        fq = '{8'h10, 8'h20, 8'h30};
        for (int i = 0; i < 3; i++) put(fq[i], 1'b0);
        clear_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'h55;
        last_i  = 1'b1;
        cycle();
        clear_i = 1'b0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        check("clear_no_done", int'(done_o), 0);
        check("clear_hold_count", int'(count_o), CMAX);
        fq = '{8'hFF, 8'hFF, 8'hFF};
        send_fq(0);
        expect_lit("after_clear", 1, 0, 3);

        // Randomized frames with gaps, aborts and resets
        for (int f = 0; f < 200; f++) begin
            len  = $urandom_range(1, 20);
            mode = $urandom_range(0, 9);
            fq.delete();
            if (len >= 3 && $urandom_range(0, 1) == 1) begin
                for (int i = 0; i < len - 2; i++) fq.push_back(DW'($urandom_range(0, 255)));
                seal();
            end else begin
                for (int i = 0; i < len; i++) fq.push_back(DW'($urandom_range(0, 255)));
            end
            abort_at = (mode >= 8) ? $urandom_range(0, len - 1) : len;
            for (int i = 0; i < fq.size(); i++) begin
                idle($urandom_range(0, 2));
                if (i == abort_at) begin
                    if (mode == 8) begin
                        clear_i = 1'b1;
                        valid_i = $urandom_range(0, 1);
                        data_i  = DW'($urandom_range(0, 255));
                        last_i  = $urandom_range(0, 1);
                        cycle();
                        clear_i = 1'b0;
                        valid_i = 1'b0;
                        last_i  = 1'b0;
                    end else begin
                        reset_i = 1'b1;
                        idle(2);
                        reset_i = 1'b0;
                    end
                    break;
                end
                put(fq[i], i == fq.size() - 1);
            end
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
